// File: rtl/voice_mix_sequencer.sv
// Per-sample voice scheduler: divides clk down to the sample tick, walks each voice
// through the shared datapath, and emits one saturated mixed sample per tick.
module voice_mix_sequencer #(
  parameter int NUM_VOICES = 3,
  parameter int SAMPLE_DIV = 1000,
  parameter int VOICE_W    = 12,
  parameter int MIX_W      = 12
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ena,
  input  logic [NUM_VOICES-1:0]     voice_mute,
  output logic [1:0]                voice_sel,
  output logic                      voice_start,
  input  logic                      voice_done,
  input  logic signed [VOICE_W-1:0] voice_data,
  output logic signed [MIX_W-1:0]   mix_out,
  output logic                      mix_valid,
  output logic                      busy,
  output logic                      overrun,
  input  logic                      overrun_clr
);

  localparam int ACC_W = VOICE_W + 2;
  localparam int CNT_W = $clog2(SAMPLE_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_DIV - 1);
  localparam logic [1:0] LAST_IDX = 2'(NUM_VOICES - 1);
  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(2 ** (MIX_W - 1) - 1);
  localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(-(2 ** (MIX_W - 1)));

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  function automatic logic signed [ACC_W-1:0] ext_voice(input logic signed [VOICE_W-1:0] v);
    return ACC_W'(v);
  endfunction

  function automatic logic signed [MIX_W-1:0] sat_mix(input logic signed [ACC_W-1:0] a);
    if (a > SAT_HI) return SAT_HI[MIX_W-1:0];
    if (a < SAT_LO) return SAT_LO[MIX_W-1:0];
    return a[MIX_W-1:0];
  endfunction

  state_t                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [1:0]                idx_q, idx_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic signed [MIX_W-1:0]   mix_out_q, mix_out_d;
  logic                      mix_valid_q, mix_valid_d;
  logic                      voice_start_q, voice_start_d;
  logic                      busy_q, busy_d;
  logic                      overrun_q, overrun_d;
  logic                      tick;
  logic [3:0]                mute_ext;

  assign mute_ext = 4'(voice_mute);
  assign tick     = ena && (cnt_q == CNT_LAST);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    acc_d         = acc_q;
    mix_out_d     = mix_out_q;
    mix_valid_d   = 1'b0;
    voice_start_d = 1'b0;
    overrun_d     = overrun_q;

    if (ena) cnt_d = tick ? '0 : cnt_q + CNT_W'(1);

    case (state_q)
      IDLE: begin
        if (tick) begin
          state_d       = ISSUE;
          acc_d         = '0;
          idx_d         = '0;
          voice_start_d = 1'b1;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (voice_done) begin
          if (!mute_ext[idx_q]) acc_d = acc_q + ext_voice(voice_data);
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            idx_d         = idx_q + 2'd1;
            state_d       = ISSUE;
            voice_start_d = 1'b1;
          end
        end
      end
      DONE: begin
        state_d     = IDLE;
        mix_out_d   = sat_mix(acc_q);
        mix_valid_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // a tick arriving mid-sequence is dropped; setting beats a same-cycle clear
    if (overrun_clr) overrun_d = 1'b0;
    if (tick && state_q != IDLE) overrun_d = 1'b1;

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      idx_q         <= '0;
      acc_q         <= '0;
      mix_out_q     <= '0;
      mix_valid_q   <= 1'b0;
      voice_start_q <= 1'b0;
      busy_q        <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      acc_q         <= acc_d;
      mix_out_q     <= mix_out_d;
      mix_valid_q   <= mix_valid_d;
      voice_start_q <= voice_start_d;
      busy_q        <= busy_d;
      overrun_q     <= overrun_d;
    end
  end

  assign voice_sel   = idx_q;
  assign voice_start = voice_start_q;
  assign mix_out     = mix_out_q;
  assign mix_valid   = mix_valid_q;
  assign busy        = busy_q;
  assign overrun     = overrun_q;

endmodule

// File: doc/voice_mix_sequencer.md
Name: voice_mix_sequencer

Overview:
- Per-sample scheduler for the shared voice datapath (oscillator/waveform/envelope pipeline) in the tt6581 synth core.
- Generates the sample-rate tick and sequences the voices through the single datapath one at a time.
- Accumulates each voice's signed output, saturates the sum, and presents one mixed sample per tick to the downstream filter/DAC stage.
- Flags overruns when the datapath cannot finish all voices within one sample period.

Parameters:
- NUM_VOICES, 3, number of voices sequenced per sample (2..4)
- SAMPLE_DIV, 1000, clk cycles per sample period (>= 4*NUM_VOICES)
- VOICE_W, 12, signed width of voice_data
- MIX_W, 12, signed width of mix_out (<= VOICE_W+2)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- ena  in  1  run enable; when low the sample counter holds its value
- voice_mute  in  NUM_VOICES  bit i=1 excludes voice i from the sum
- voice_sel  out  2  index of the voice being processed
- voice_start  out  1  one-cycle pulse requesting the datapath to compute voice_sel
- voice_done  in  1  datapath result valid; sampled only in WAIT
- voice_data  in  VOICE_W  signed voice sample, valid with voice_done
- mix_out  out  MIX_W  saturated signed mixed sample
- mix_valid  out  1  one-cycle pulse; mix_out updated at the same edge
- busy  out  1  high whenever state != IDLE
- overrun  out  1  sticky overrun flag
- overrun_clr  in  1  clears overrun

Behaviour:
- Reset: state=IDLE, div counter=0, idx=0, acc=0; all outputs 0 (voice_sel, voice_start, mix_out, mix_valid, busy, overrun).
- Reset asserted mid-sequence: sequence aborted, no mix_valid, mix_out cleared.
- Divider: counts 0..SAMPLE_DIV-1 while ena=1, then wraps to 0. tick=1 in the cycle the counter equals SAMPLE_DIV-1 and ena=1. ena=0 freezes the counter but does not abort an in-flight sequence.
- FSM:
  - IDLE: on tick -> ISSUE; acc<=0; idx<=0.
  - ISSUE: voice_start=1 and voice_sel=idx for exactly one cycle -> WAIT.
  - WAIT: voice_sel held. On voice_done, if voice_mute[idx]=0, acc<=acc+sext(voice_data). Then if idx==NUM_VOICES-1 -> DONE, else idx<=idx+1 and -> ISSUE. voice_done in any other state is ignored.
  - DONE: at the exiting edge, mix_out<=sat(acc) and mix_valid<=1 for one cycle -> IDLE.
- Arithmetic:
  - acc width is VOICE_W+2, signed; it cannot overflow.
  - sat(): clamp to [-2^(MIX_W-1), 2^(MIX_W-1)-1].
  - voice_mute is sampled in the WAIT cycle where voice_done is high.
- Latency: voice_start is asserted the cycle after tick. mix_valid is high 2 cycles after the cycle in which the final voice_done is sampled.
- Overrun:
  - tick while state != IDLE sets overrun, and that tick is dropped (no new sequence).
  - overrun_clr clears overrun.
  - Simultaneous set and clr: set wins.
- Voice data is never lost: the datapath waits indefinitely for voice_done (no timeout).
- mix_out holds its value between mix_valid pulses.

Test Plan:
- SAMPLE_DIV=64, ena=1, datapath answers 3 cycles after start with voice data 100, -50, 25 -> voice_start pulses with voice_sel 0,1,2; mix_out=75 with a single mix_valid pulse; the next sequence starts exactly 64 cycles after the previous tick.
- Voice data 2000, 2000, 2000 -> mix_out=2047 (saturated). Voice data -2048, -2048, -1 -> mix_out=-2048.
- voice_mute=3'b010 with data 100, -50, 25 -> mix_out=125. All voices muted -> mix_out=0, mix_valid still pulses.
- Datapath delays voice_done 70 cycles with SAMPLE_DIV=64 -> overrun=1, exactly one sequence completes, the dropped tick starts nothing. overrun_clr=1 in the same cycle as a second overrun -> overrun remains 1.
- rst pulsed while in WAIT for voice 1 -> all outputs 0 next cycle, no mix_valid. After release, the first voice_start comes SAMPLE_DIV cycles later.
- ena dropped mid-sequence -> the sequence completes and mix_valid pulses, then no further ticks. ena reasserted -> the counter resumes from its held value.
